piso_tx: RTL and testbench
==========================

PISO_TX -- requirements
Module: piso_tx

Interface
- REQ-001: The block SHALL have parameter WIDTH, default 8, giving the parallel word width in bits; legal range 2..32.
- REQ-002: The block SHALL have parameter MSB_FIRST, default 1; 1 sends bit WIDTH-1 first, 0 sends bit 0 first.
- REQ-003: Port clk, input, 1 bit: single clock; all state changes occur on its rising edge.
- REQ-004: Port rst, input, 1 bit: reset, synchronous and active-high.
- REQ-005: Port in_data, input, WIDTH bits: parallel word to serialize, sampled only on load.
- REQ-006: Port in_valid, input, 1 bit: upstream offers in_data.
- REQ-007: Port in_ready, output, 1 bit: block can accept a word this cycle.
- REQ-008: Port ser_out, output, 1 bit: current serial bit, registered.
- REQ-009: Port ser_valid, output, 1 bit: ser_out holds a valid bit.
- REQ-010: Port ser_last, output, 1 bit: ser_out is the final bit of the word.
- REQ-011: Port ser_ready, input, 1 bit: downstream accepts the bit; a bit transfers on any cycle where ser_valid and ser_ready are both 1.
- REQ-012: Port busy, output, 1 bit: a word is held and not fully transferred.

Function
- REQ-013: FSM states SHALL be IDLE and SHIFT; no other reachable states.
- REQ-014: In IDLE: in_ready=1, ser_valid=0, ser_last=0, busy=0, ser_out=0.
- REQ-015: In IDLE with in_valid=1, the block SHALL capture in_data into the shift register, clear the bit counter to 0, and enter SHIFT on the next edge.
- REQ-016: In SHIFT: in_ready=0, busy=1, ser_valid=1; in_valid is ignored and in_data is not sampled.
- REQ-017: Latency: word accepted at edge N, first bit SHALL be on ser_out with ser_valid=1 in the cycle after edge N.
- REQ-018: On each transfer in SHIFT, the shift register SHALL advance one position in the MSB_FIRST direction and the counter SHALL increment by 1.
- REQ-019: When ser_valid=1 and ser_ready=0 (stall), ser_out, ser_last, the counter and the shift register SHALL hold unchanged for any number of cycles.
- REQ-020: ser_last SHALL be 1 exactly when the counter equals WIDTH-1 in SHIFT.
- REQ-021: A transfer with ser_last=1 SHALL return the FSM to IDLE, so in_ready=1 in the following cycle.
- REQ-022: Throughput with ser_ready held at 1 SHALL be one word per WIDTH+1 cycles (WIDTH bit cycles plus one IDLE load cycle).
- REQ-023: Exactly WIDTH transfers SHALL occur per accepted word; no bit is dropped, duplicated or reordered.
- REQ-024: ser_ready toggling while the FSM is in IDLE SHALL have no effect.

Reset
- REQ-025: While rst=1 at a rising edge, the FSM SHALL go to IDLE, the counter and shift register SHALL clear to 0, and the outputs SHALL take the IDLE values (in_ready=1, ser_out=0, ser_valid=0, ser_last=0, busy=0) from the next cycle.
- REQ-026: Reset SHALL have priority over load and transfer; a word in progress SHALL be discarded with no further bits emitted.
- REQ-027: The FSM SHALL have no reachable illegal state; any undefined encoding SHALL recover to IDLE on the next edge.

Verification
- REQ-028: WIDTH=8, MSB_FIRST=1, in_data=0xB4, ser_ready=1 -> ser_out sequence 1,0,1,1,0,1,0,0; ser_last only on the 8th bit; in_ready=1 in cycle 10.
- REQ-029: WIDTH=8, MSB_FIRST=0, in_data=0xB4, ser_ready=1 -> ser_out sequence 0,0,1,0,1,1,0,1.
- REQ-030: 0xB4 MSB-first with ser_ready=0 for 3 cycles after the 2nd bit -> ser_out holds 1 for all stall cycles; the full sequence is unchanged and ends 3 cycles later.
- REQ-031: in_valid held at 1 with 0x11 then 0xEE, ser_ready=1 -> 0xEE is accepted only on the IDLE cycle after 0x11's last bit; the 16 bits are correct and in order.
- REQ-032: rst=1 asserted after the 4th bit of 0xFF -> next cycle ser_valid=0, in_ready=1, ser_out=0; the next word 0x0F then serializes fully and correctly.
- REQ-033: WIDTH=2, in_data=0b10, MSB_FIRST=1 -> bits 1,0; ser_last=1 on the 2nd bit.

Source files
------------

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: accepts one WIDTH-bit word per valid/ready
// handshake and emits it bit by bit on a valid/ready serial stream.
module piso_tx #(
   parameter int unsigned WIDTH     = 8,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             ser_out,
   output logic             ser_valid,
   output logic             ser_last,
   input  logic             ser_ready,
   output logic             busy
);

   localparam int unsigned    CW       = $clog2(WIDTH);
   localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sr_q, sr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             ser_out_q, ser_out_d;
   logic             ser_valid_q, ser_valid_d;
   logic             ser_last_q, ser_last_d;
   logic             in_ready_q, in_ready_d;
   logic             busy_q, busy_d;
   logic [WIDTH-1:0] sr_adv;

   function automatic logic head(input logic [WIDTH-1:0] v);
      return MSB_FIRST ? v[WIDTH-1] : v[0];
   endfunction

   // Rotate rather than shift in zeros; the register is cleared when the word completes.
   assign sr_adv = MSB_FIRST ? {sr_q[WIDTH-2:0], sr_q[WIDTH-1]}
                             : {sr_q[0], sr_q[WIDTH-1:1]};

   always_comb begin
      state_d     = state_q;
      sr_d        = sr_q;
      cnt_d       = cnt_q;
      ser_out_d   = ser_out_q;
      ser_valid_d = ser_valid_q;
      ser_last_d  = ser_last_q;
      in_ready_d  = in_ready_q;
      busy_d      = busy_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               state_d     = SHIFT;
               sr_d        = in_data;
               cnt_d       = '0;
               ser_out_d   = head(in_data);
               ser_valid_d = 1'b1;
               ser_last_d  = 1'b0;
               in_ready_d  = 1'b0;
               busy_d      = 1'b1;
            end
         end
         SHIFT: begin
            if (ser_ready) begin
               if (cnt_q == LAST_CNT) begin
                  state_d     = IDLE;
                  sr_d        = '0;
                  cnt_d       = '0;
                  ser_out_d   = 1'b0;
                  ser_valid_d = 1'b0;
                  ser_last_d  = 1'b0;
                  in_ready_d  = 1'b1;
                  busy_d      = 1'b0;
               end else begin
                  sr_d       = sr_adv;
                  cnt_d      = cnt_q + 1'b1;
                  ser_out_d  = head(sr_adv);
                  ser_last_d = ((cnt_q + 1'b1) == LAST_CNT);
               end
            end
         end
         default: begin
            state_d     = IDLE;
            sr_d        = '0;
            cnt_d       = '0;
            ser_out_d   = 1'b0;
            ser_valid_d = 1'b0;
            ser_last_d  = 1'b0;
            in_ready_d  = 1'b1;
            busy_d      = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         sr_q        <= '0;
         cnt_q       <= '0;
         ser_out_q   <= 1'b0;
         ser_valid_q <= 1'b0;
         ser_last_q  <= 1'b0;
         in_ready_q  <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         sr_q        <= sr_d;
         cnt_q       <= cnt_d;
         ser_out_q   <= ser_out_d;
         ser_valid_q <= ser_valid_d;
         ser_last_q  <= ser_last_d;
         in_ready_q  <= in_ready_d;
         busy_q      <= busy_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign ser_out   = ser_out_q;
   assign ser_valid = ser_valid_q;
   assign ser_last  = ser_last_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx: three instances (8-bit MSB-first, 8-bit LSB-first, 2-bit MSB-first)
// checked every cycle against a queue-of-bits model plus literal stream/latency checks.
module tb_piso_tx;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic [7:0] d_ab;
   logic       iv_ab, sr_ab;
   logic [1:0] d_c;
   logic       iv_c, sr_c;
   logic [2:0] ir, so, sv, sl, bz;

   piso_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) u_a (
      .clk(clk), .rst(rst), .in_data(d_ab), .in_valid(iv_ab), .in_ready(ir[0]),
      .ser_out(so[0]), .ser_valid(sv[0]), .ser_last(sl[0]), .ser_ready(sr_ab), .busy(bz[0]));
   piso_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) u_b (
      .clk(clk), .rst(rst), .in_data(d_ab), .in_valid(iv_ab), .in_ready(ir[1]),
      .ser_out(so[1]), .ser_valid(sv[1]), .ser_last(sl[1]), .ser_ready(sr_ab), .busy(bz[1]));
   piso_tx #(.WIDTH(2), .MSB_FIRST(1'b1)) u_c (
      .clk(clk), .rst(rst), .in_data(d_c), .in_valid(iv_c), .in_ready(ir[2]),
      .ser_out(so[2]), .ser_valid(sv[2]), .ser_last(sl[2]), .ser_ready(sr_c), .busy(bz[2]));

   int ncmp = 0;
   int nbad = 0;
   int cyc  = 0;
   bit armed = 1'b0;

   // Model: pending bits in send order (bit 0 goes next) and how many remain.
   logic [31:0]  mbits [3];
   int           mcnt  [3];
   logic [255:0] capv  [3];
   int           capn  [3];

   initial begin
      for (int i = 0; i < 3; i++) begin
         mbits[i] = '0;
         mcnt[i]  = 0;
         capv[i]  = '0;
         capn[i]  = 0;
      end
   end

   function automatic int wid(input int i);
      return (i == 2) ? 2 : 8;
   endfunction

   function automatic bit msbf(input int i);
      return (i != 1);
   endfunction

   function automatic logic [31:0] din(input int i);
      return (i == 2) ? {30'b0, d_c} : {24'b0, d_ab};
   endfunction

   function automatic logic ivf(input int i);
      return (i == 2) ? iv_c : iv_ab;
   endfunction

   function automatic logic srf(input int i);
      return (i == 2) ? sr_c : sr_ab;
   endfunction

   function automatic logic [31:0] load_bits(input int i);
      logic [31:0] r;
      logic [31:0] v;
      r = '0;
      v = din(i);
      for (int k = 0; k < wid(i); k++)
         r[k] = msbf(i) ? v[wid(i) - 1 - k] : v[k];
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      ncmp++;
      if (got !== exp) begin
         nbad++;
         $display("FAIL %s at t=%0t: got %0h, expected %0h", nm, $time, got, exp);
      end
   endtask

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rst) armed <= 1'b1;
      for (int i = 0; i < 3; i++) begin
         if (rst) begin
            mcnt[i]  <= 0;
            mbits[i] <= '0;
         end else if (mcnt[i] != 0) begin
            if (srf(i)) begin
               mbits[i] <= mbits[i] >> 1;
               mcnt[i]  <= mcnt[i] - 1;
            end
         end else if (ivf(i)) begin
            mbits[i] <= load_bits(i);
            mcnt[i]  <= wid(i);
         end
      end
   end

   always @(negedge clk) begin
      if (armed) begin
         for (int i = 0; i < 3; i++) begin
            chk($sformatf("in_ready[%0d]", i), {31'b0, ir[i]}, {31'b0, mcnt[i] == 0});
            chk($sformatf("ser_valid[%0d]", i), {31'b0, sv[i]}, {31'b0, mcnt[i] != 0});
            chk($sformatf("busy[%0d]", i), {31'b0, bz[i]}, {31'b0, mcnt[i] != 0});
            chk($sformatf("ser_last[%0d]", i), {31'b0, sl[i]}, {31'b0, mcnt[i] == 1});
            chk($sformatf("ser_out[%0d]", i), {31'b0, so[i]},
                {31'b0, (mcnt[i] != 0) ? mbits[i][0] : 1'b0});
            if (sv[i] && srf(i) && capn[i] < 256) begin
               capv[i][capn[i]] <= so[i];
               capn[i]          <= capn[i] + 1;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready(input int i, input int maxc, output int c);
      c = -1;
      for (int n = 0; n < maxc; n++) begin
         tick();
         @(negedge clk);
         if (ir[i]) begin
            c = cyc;
            break;
         end
      end
      if (c < 0) chk($sformatf("ready_timeout[%0d]", i), 32'd0, 32'd1);
   endtask

   // Expected stream written with the first-sent bit as the MSB of an n-bit value.
   task automatic chk_stream(input string nm, input int i, input int base, input int n,
                             input logic [31:0] expv);
      logic [31:0] gv;
      gv = '0;
      chk({nm, "_count"}, capn[i] - base, n);
      for (int k = 0; k < n; k++) gv[n - 1 - k] = capv[i][base + k];
      chk({nm, "_bits"}, gv, expv);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int b0, b1, b2, t_load, t_rdy, t_rdy2;
      rst = 1'b1; d_ab = '0; iv_ab = 1'b0; sr_ab = 1'b1;
      d_c = '0; iv_c = 1'b0; sr_c = 1'b0;
      repeat (2) tick();
      rst = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", {31'b0, ir[0]}, 32'd1);
      chk("rst_ser_valid", {31'b0, sv[0]}, 32'd0);
      chk("rst_ser_out", {31'b0, so[0]}, 32'd0);
      chk("rst_busy_c", {31'b0, bz[2]}, 32'd0);

      // 0xB4 with ser_ready held high
      tick(); b0 = capn[0]; b1 = capn[1];
      d_ab = 8'hB4; iv_ab = 1'b1; sr_ab = 1'b1; t_load = cyc;
      @(negedge clk);
      chk("t1_load_ready", {31'b0, ir[0]}, 32'd1);
      tick(); iv_ab = 1'b0;
      @(negedge clk);
      chk("t1_first_bit_a", {31'b0, so[0]}, 32'd1);
      chk("t1_first_bit_b", {31'b0, so[1]}, 32'd0);
      wait_ready(0, 20, t_rdy);
      chk("t1_ready_cycle", t_rdy - t_load, 32'd9);
      chk_stream("t1_stream_a", 0, b0, 8, 32'hB4);
      chk_stream("t1_stream_b", 1, b1, 8, 32'h2D);

      // 0xB4 with a 3-cycle stall after the 2nd bit
      tick(); b0 = capn[0]; b1 = capn[1];
      d_ab = 8'hB4; iv_ab = 1'b1; t_load = cyc;
      tick(); iv_ab = 1'b0;
      tick();
      tick(); sr_ab = 1'b0;
      for (int s = 0; s < 3; s++) begin
         if (s > 0) tick();
         @(negedge clk);
         chk("t2_stall_out", {31'b0, so[0]}, 32'd1);
         chk("t2_stall_valid", {31'b0, sv[0]}, 32'd1);
      end
      tick(); sr_ab = 1'b1;
      wait_ready(0, 20, t_rdy);
      chk("t2_ready_cycle", t_rdy - t_load, 32'd12);
      chk_stream("t2_stream_a", 0, b0, 8, 32'hB4);
      chk_stream("t2_stream_b", 1, b1, 8, 32'h2D);

      // Back-to-back words with in_valid held high
      tick(); b0 = capn[0]; b1 = capn[1];
      d_ab = 8'h11; iv_ab = 1'b1; t_load = cyc;
      tick(); d_ab = 8'hEE;
      wait_ready(0, 20, t_rdy);
      chk("t3_second_accept", t_rdy - t_load, 32'd9);
      tick(); iv_ab = 1'b0;
      wait_ready(0, 20, t_rdy2);
      chk("t3_second_done", t_rdy2 - t_rdy, 32'd9);
      chk_stream("t3_stream_a", 0, b0, 16, 32'h11EE);
      chk_stream("t3_stream_b", 1, b1, 16, 32'h8877);

      // Reset in the middle of 0xFF, then 0x0F
      tick(); d_ab = 8'hFF; iv_ab = 1'b1;
      tick(); iv_ab = 1'b0;
      repeat (3) tick();
      tick(); rst = 1'b1;
      tick(); rst = 1'b0;
      @(negedge clk);
      chk("t4_rst_valid", {31'b0, sv[0]}, 32'd0);
      chk("t4_rst_ready", {31'b0, ir[0]}, 32'd1);
      chk("t4_rst_out", {31'b0, so[0]}, 32'd0);
      chk("t4_rst_valid_b", {31'b0, sv[1]}, 32'd0);
      tick(); b0 = capn[0]; b1 = capn[1];
      d_ab = 8'h0F; iv_ab = 1'b1; t_load = cyc;
      tick(); iv_ab = 1'b0;
      wait_ready(0, 20, t_rdy);
      chk("t4_ready_cycle", t_rdy - t_load, 32'd9);
      chk_stream("t4_stream_a", 0, b0, 8, 32'h0F);
      chk_stream("t4_stream_b", 1, b1, 8, 32'hF0);

      // 2-bit instance: ser_ready toggling in IDLE, then 0b10
      for (int k = 0; k < 6; k++) begin
         tick(); sr_c = k[0];
      end
      @(negedge clk);
      chk("t5_idle_ready", {31'b0, ir[2]}, 32'd1);
      tick(); b2 = capn[2];
      sr_c = 1'b1; d_c = 2'b10; iv_c = 1'b1; t_load = cyc;
      tick(); iv_c = 1'b0;
      @(negedge clk);
      chk("t5_bit1_out", {31'b0, so[2]}, 32'd1);
      chk("t5_bit1_last", {31'b0, sl[2]}, 32'd0);
      tick();
      @(negedge clk);
      chk("t5_bit2_out", {31'b0, so[2]}, 32'd0);
      chk("t5_bit2_last", {31'b0, sl[2]}, 32'd1);
      wait_ready(2, 10, t_rdy);
      chk("t5_ready_cycle", t_rdy - t_load, 32'd3);
      chk_stream("t5_stream_c", 2, b2, 2, 32'h2);

      // 2-bit instance with a stall on the first bit
      tick(); b2 = capn[2];
      sr_c = 1'b0; d_c = 2'b01; iv_c = 1'b1;
      tick(); iv_c = 1'b0;
      repeat (2) tick();
      sr_c = 1'b1;
      wait_ready(2, 10, t_rdy);
      chk_stream("t5_stall_stream_c", 2, b2, 2, 32'h1);

      tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
      $finish;
   end

endmodule
